// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter and fetch/issue/execute sequencer
module pc_fetch_sequencer #(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [PC_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0] instr,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                exec_done,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] instr_q, instr_d;
  logic [15:0]         retired_q, retired_d;
  logic [PC_WIDTH-1:0] pc_inc;

  // Sequential PC increment wraps naturally at the register width.
  assign pc_inc = pc_q + PC_WIDTH'(1);

  // State and architectural registers; reset abandons any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_VECTOR;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic; each handshake input only matters in its own phase.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (instr_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          retired_d = retired_q + 16'd1;
          if (halt) begin
            state_d = S_HALT;
          end else begin
            pc_d    = branch_taken ? branch_target : pc_inc;
            state_d = run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_HALT: begin
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from registered state only.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign pc          = pc_q;
  assign pc_plus1    = pc_inc;
  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);
  assign retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        exec_done;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  int n_vec;
  int n_err;

  pc_fetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halt         (halt),
    .pc           (pc),
    .pc_plus1     (pc_plus1),
    .busy         (busy),
    .halted       (halted),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Runs one instruction from FETCH with single-cycle ack, ready and done.
  task automatic run_one(input logic [15:0] word, input logic br, input logic [15:0] tgt,
                         input logic hlt);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready   = 1'b0;
    exec_done     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    halt          = hlt;
    step();
    exec_done    = 1'b0;
    branch_taken = 1'b0;
    halt         = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    run = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    instr_ready = 1'b0;
    exec_done = 1'b0;
    branch_taken = 1'b0;
    branch_target = 16'h0000;
    halt = 1'b0;
    step();
    step();

    // reset state
    chk16("rst_pc", pc, 16'h0000);
    chk16("rst_pc_plus1", pc_plus1, 16'h0001);
    chk16("rst_instr", instr, 16'h0000);
    chk16("rst_retired", retired, 16'h0000);
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_halted", halted, 1'b0);

    // three back-to-back sequential instructions
    rst_n = 1'b1;
    run = 1'b1;
    imem_ack = 1'b1;
    instr_ready = 1'b1;
    exec_done = 1'b1;
    imem_rdata = 16'hA000;
    step();
    chk1("seq_req0", imem_req, 1'b1);
    chk16("seq_addr0", imem_addr, 16'h0000);
    step();
    chk1("seq_valid0", instr_valid, 1'b1);
    chk16("seq_instr0", instr, 16'hA000);
    imem_rdata = 16'hA001;
    step();
    chk1("seq_exec_valid0", instr_valid, 1'b0);
    chk1("seq_exec_busy0", busy, 1'b1);
    step();
    chk16("seq_addr1", imem_addr, 16'h0001);
    chk16("seq_retired1", retired, 16'h0001);
    step();
    chk1("seq_valid1", instr_valid, 1'b1);
    chk16("seq_instr1", instr, 16'hA001);
    imem_rdata = 16'hA002;
    step();
    step();
    chk16("seq_addr2", imem_addr, 16'h0002);
    chk16("seq_retired2", retired, 16'h0002);
    step();
    chk1("seq_valid2", instr_valid, 1'b1);
    chk16("seq_instr2", instr, 16'hA002);
    step();
    run = 1'b0;
    step();
    chk16("seq_retired3", retired, 16'h0003);
    chk16("seq_pc3", pc, 16'h0003);
    chk1("pause_busy", busy, 1'b0);
    chk1("pause_req", imem_req, 1'b0);
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    exec_done = 1'b0;

    // branches
    run = 1'b1;
    step();
    chk16("resume_addr", imem_addr, 16'h0003);
    run_one(16'h1111, 1'b1, 16'h0010, 1'b0);
    chk16("br1_pc", pc, 16'h0010);
    chk16("br1_retired", retired, 16'h0004);
    run_one(16'h2222, 1'b1, 16'h0200, 1'b0);
    chk16("br2_addr", imem_addr, 16'h0200);
    chk16("br2_pc_plus1", pc_plus1, 16'h0201);
    chk1("br2_req", imem_req, 1'b1);
    chk16("br2_retired", retired, 16'h0005);

    // wrap at 16'hFFFF
    run_one(16'h3333, 1'b1, 16'hFFFF, 1'b0);
    chk16("wrap_pc", pc, 16'hFFFF);
    chk16("wrap_pc_plus1", pc_plus1, 16'h0000);
    run_one(16'h4444, 1'b0, 16'h0000, 1'b0);
    chk16("wrap_addr", imem_addr, 16'h0000);
    chk1("wrap_req", imem_req, 1'b1);
    chk16("wrap_retired", retired, 16'h0007);

    // halt wins over branch
    run_one(16'h5555, 1'b1, 16'h1234, 1'b1);
    chk1("halt_halted", halted, 1'b1);
    chk1("halt_busy", busy, 1'b0);
    chk1("halt_req", imem_req, 1'b0);
    chk16("halt_pc", pc, 16'h0000);
    chk16("halt_retired", retired, 16'h0008);
    chk16("halt_instr", instr, 16'h5555);
    step();
    chk1("halt_stay", halted, 1'b1);
    run = 1'b0;
    step();
    chk1("halt_idle_halted", halted, 1'b0);
    chk1("halt_idle_busy", busy, 1'b0);
    chk1("halt_idle_req", imem_req, 1'b0);
    run = 1'b1;
    step();
    chk1("halt_resume_req", imem_req, 1'b1);
    chk16("halt_resume_addr", imem_addr, 16'h0000);

    // stalled ack and ready, spurious exec_done in ISSUE
    for (int i = 0; i < 4; i++) begin
      chk1("stall_req", imem_req, 1'b1);
      step();
    end
    chk1("stall_req_last", imem_req, 1'b1);
    imem_ack = 1'b1;
    imem_rdata = 16'hBEEF;
    step();
    imem_ack = 1'b0;
    imem_rdata = 16'h0BAD;
    chk1("stall_issue_req", imem_req, 1'b0);
    chk1("stall_valid0", instr_valid, 1'b1);
    chk16("stall_instr0", instr, 16'hBEEF);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    chk1("stall_valid1", instr_valid, 1'b1);
    chk16("stall_instr1", instr, 16'hBEEF);
    step();
    chk1("stall_valid2", instr_valid, 1'b1);
    chk16("stall_instr2", instr, 16'hBEEF);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk1("stall_exec_valid", instr_valid, 1'b0);
    chk1("stall_exec_busy", busy, 1'b1);
    chk16("stall_exec_retired", retired, 16'h0008);
    chk16("stall_exec_pc", pc, 16'h0000);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    chk16("stall_done_pc", pc, 16'h0001);
    chk16("stall_done_retired", retired, 16'h0009);

    // asynchronous reset mid-FETCH
    run_one(16'h6666, 1'b1, 16'h0042, 1'b0);
    chk16("prerst_addr", imem_addr, 16'h0042);
    chk1("prerst_req", imem_req, 1'b1);
    run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_req", imem_req, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk16("arst_pc", pc, 16'h0000);
    chk16("arst_pc_plus1", pc_plus1, 16'h0001);
    chk16("arst_retired", retired, 16'h0000);
    chk16("arst_instr", instr, 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    chk1("arst_idle_req", imem_req, 1'b0);
    chk1("arst_idle_busy", busy, 1'b0);
    run = 1'b1;
    step();
    chk1("arst_fetch_req", imem_req, 1'b1);
    chk16("arst_fetch_addr", imem_addr, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Controls the 16-bit program counter and the instruction fetch loop for the final-project processor.
- Steps through four phases: request the instruction at PC from instruction memory, hand it to the core, wait for execution to finish, then select the next PC.
- The next PC is either PC+1 (16-bit wrap) or a taken-branch target.
- Sits between the instruction memory and the core control/datapath; owns the only architectural PC register.

Parameters:
- PC_WIDTH, 16, width of PC, memory address, branch target and instruction.
- RESET_VECTOR, 16'h0000, PC value loaded by reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  enable instruction sequencing.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  PC_WIDTH  fetch address; always equals pc.
- imem_ack  input  1  memory has returned data on imem_rdata this cycle.
- imem_rdata  input  PC_WIDTH  fetched instruction word.
- instr  output  PC_WIDTH  captured instruction to the core.
- instr_valid  output  1  instr is valid and offered to the core.
- instr_ready  input  1  core accepts instr.
- exec_done  input  1  core has finished the current instruction.
- branch_taken  input  1  next PC comes from branch_target; qualified by exec_done.
- branch_target  input  PC_WIDTH  branch or jump destination.
- halt  input  1  instruction was HALT; qualified by exec_done.
- pc  output  PC_WIDTH  current PC register.
- pc_plus1  output  PC_WIDTH  combinational pc+1, modulo 2^PC_WIDTH.
- busy  output  1  high in FETCH, ISSUE and EXEC.
- halted  output  1  high in HALT.
- retired  output  16  count of completed instructions, wraps at 16'hFFFF.

Behaviour:

Reset (rst_n low, asynchronous):
- State IDLE, pc=RESET_VECTOR, instr=0, retired=0.
- imem_req, instr_valid, busy and halted are all 0; pc_plus1=RESET_VECTOR+1.

Outputs:
- All outputs are Moore, decoded from state and registers.
- No combinational path from any input to any output.

State IDLE:
- busy=0.
- If run=1 at a clock edge, go to FETCH.
- pc is retained; it is not reloaded from RESET_VECTOR.

State FETCH:
- imem_req=1, imem_addr=pc.
- Hold until imem_ack=1. On that edge, instr<=imem_rdata and go to ISSUE.
- imem_ack outside FETCH is ignored.

State ISSUE:
- instr_valid=1; instr is held stable.
- On instr_ready=1, go to EXEC.
- instr_ready outside ISSUE is ignored.

State EXEC: wait for exec_done=1. On that edge, the first matching rule applies:
- halt=1: pc unchanged, retired+1, go to HALT. halt takes priority over branch_taken.
- branch_taken=1: pc<=branch_target, retired+1.
- otherwise: pc<=pc_plus1 (16'hFFFF wraps to 16'h0000), retired+1.
- Next state after a branch or PC+1 update: FETCH if run=1, else IDLE (pause at an instruction boundary).
- halt, branch_taken and branch_target are ignored unless exec_done=1 in EXEC.

State HALT:
- halted=1, busy=0.
- Stay in HALT while run=1. run=0 moves to IDLE; a later run=1 resumes fetching at the retained pc.

run deasserted during FETCH or ISSUE:
- No effect; the instruction in flight completes.

Throughput:
- Minimum 3 cycles per instruction, when imem_ack, instr_ready and exec_done each arrive in the first cycle of their state.
- Each wait state may stall indefinitely; there is no timeout.

Reset mid-operation:
- Immediate return to the reset values above.
- An outstanding imem_req is dropped; memory must tolerate an abandoned request.

Test Plan:
- Reset, then run=1, with single-cycle ack/ready/done and no branches → imem_addr sequence 0000,0001,0002; instructions issued 3 cycles apart; retired=3 after the third exec_done.
- pc=16'h0010, exec_done with branch_taken=1 and branch_target=16'h0200 → next imem_addr=16'h0200; pc_plus1=16'h0201.
- pc=16'hFFFF, exec_done with no branch → pc=16'h0000 and the fetch wraps.
- exec_done with halt=1 and branch_taken=1 together → HALT, pc unchanged, halted=1. Then run=0 → IDLE; run=1 → fetch at the same pc.
- imem_ack delayed 4 cycles and instr_ready delayed 2 cycles → imem_req held 5 cycles, instr_valid held 3 cycles with instr stable; spurious exec_done during ISSUE ignored.
- rst_n pulsed low mid-FETCH at pc=16'h0042 → outputs go to reset values immediately; pc=RESET_VECTOR; retired=0; state IDLE.
